// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// ALU/PC select codes and the bundled control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_JUMP_EX  = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REG      = 2'b00,
    SRCB_FOUR     = 2'b01,
    SRCB_IMM      = 2'b10,
    SRCB_IMM_SHL2 = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic     pcwrite;
    logic     branch;
    logic     iord;
    logic     memread;
    logic     memwrite;
    logic     irwrite;
    logic     regdst;
    logic     memtoreg;
    logic     regwrite;
    logic     alusrca;
    alusrcb_t alusrcb;
    aluop_t   aluop;
    pcsrc_t   pcsrc;
    logic     illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_control_outs.sv
// State-to-control decode. Pure Moore except the FETCH IR/PC loads, which
// wait for the memory to deliver the instruction.
module mc_control_outs
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   ready,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: the whole word defaults to zero first so no state path can infer a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = ready;
        ctrl.pcwrite = ready;
      end
      S_DECODE:   ctrl.alusrcb = SRCB_IMM_SHL2;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDI_WB:  ctrl.regwrite = 1'b1;
      S_JUMP_EX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      S_TRAP:     ctrl.illegal = 1'b1;
      default:    ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: state register, latched opcode and next-state
// logic; output decoding lives in mc_control_outs.
module mc_control
  import mips_pkg::*;
#(
  parameter bit MEM_HS  = 1'b1,
  parameter bit ADDI_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       ready;
  ctrl_t      ctrl;

  // Reset masks the handshake so FETCH never loads IR/PC while held in reset.
  assign ready = (MEM_HS ? mem_ready : 1'b1) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      // NOTE: non-blocking, so op_q and state_q both see pre-edge values.
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_J:         state_d = S_JUMP_EX;
          OP_ADDI:      state_d = ADDI_EN ? S_ADDI_EX : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (ready) state_d = S_MEMWB;
      S_MEMWR:    if (ready) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_control_outs u_outs (
    .state (state_q),
    .ready (ready),
    .ctrl  (ctrl)
  );

  assign pcwrite  = ctrl.pcwrite;
  assign branch   = ctrl.branch;
  assign iord     = ctrl.iord;
  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsrc    = ctrl.pcsrc;
  assign illegal  = ctrl.illegal;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: one handshaking/addi-enabled instance and one with
// MEM_HS=0, ADDI_EN=0, both checked cycle by cycle against an instruction-path model.
module tb_mc_control;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;

  logic       a_pcwrite, a_branch, a_iord, a_memread, a_memwrite, a_irwrite;
  logic       a_regdst, a_memtoreg, a_regwrite, a_alusrca, a_illegal;
  logic [1:0] a_alusrcb, a_aluop, a_pcsrc;
  logic [3:0] a_state;
  logic       b_pcwrite, b_branch, b_iord, b_memread, b_memwrite, b_irwrite;
  logic       b_regdst, b_memtoreg, b_regwrite, b_alusrca, b_illegal;
  logic [1:0] b_alusrcb, b_aluop, b_pcsrc;
  logic [3:0] b_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  state_t path[$];

  // Bit positions of the 17-bit observation word.
  localparam int B_PCWRITE = 16, B_BRANCH = 15, B_IORD = 14, B_MEMREAD = 13;
  localparam int B_MEMWRITE = 12, B_IRWRITE = 11, B_REGDST = 10, B_MEMTOREG = 9;
  localparam int B_REGWRITE = 8, B_ALUSRCA = 7, B_SRCB = 5, B_ALUOP = 3;
  localparam int B_PCSRC = 1, B_ILLEGAL = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(a_pcwrite), .branch(a_branch), .iord(a_iord), .memread(a_memread),
    .memwrite(a_memwrite), .irwrite(a_irwrite), .regdst(a_regdst),
    .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .aluop(a_aluop), .pcsrc(a_pcsrc),
    .illegal(a_illegal), .state(a_state)
  );

  mc_control #(.MEM_HS(1'b0), .ADDI_EN(1'b0)) dut_alt (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(b_pcwrite), .branch(b_branch), .iord(b_iord), .memread(b_memread),
    .memwrite(b_memwrite), .irwrite(b_irwrite), .regdst(b_regdst),
    .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
    .alusrcb(b_alusrcb), .aluop(b_aluop), .pcsrc(b_pcsrc),
    .illegal(b_illegal), .state(b_state)
  );

  function automatic logic [16:0] obs_vec(input bit alt);
    if (alt)
      return {b_pcwrite, b_branch, b_iord, b_memread, b_memwrite, b_irwrite,
              b_regdst, b_memtoreg, b_regwrite, b_alusrca, b_alusrcb, b_aluop,
              b_pcsrc, b_illegal};
    return {a_pcwrite, a_branch, a_iord, a_memread, a_memwrite, a_irwrite,
            a_regdst, a_memtoreg, a_regwrite, a_alusrca, a_alusrcb, a_aluop,
            a_pcsrc, a_illegal};
  endfunction

  function automatic logic [3:0] obs_state(input bit alt);
    return alt ? b_state : a_state;
  endfunction

  // Required control word for a state, written straight from the state table.
  function automatic logic [16:0] exp_vec(input state_t s, input bit rdy);
    logic [16:0] v;
    v = '0;
    case (s)
      S_FETCH: begin
        v[B_MEMREAD] = 1'b1; v[B_SRCB+:2] = 2'b01;
        if (rdy) begin v[B_IRWRITE] = 1'b1; v[B_PCWRITE] = 1'b1; end
      end
      S_DECODE:   v[B_SRCB+:2] = 2'b11;
      S_MEMADR:   begin v[B_ALUSRCA] = 1'b1; v[B_SRCB+:2] = 2'b10; end
      S_MEMRD:    begin v[B_MEMREAD] = 1'b1; v[B_IORD] = 1'b1; end
      S_MEMWB:    begin v[B_MEMTOREG] = 1'b1; v[B_REGWRITE] = 1'b1; end
      S_MEMWR:    begin v[B_MEMWRITE] = 1'b1; v[B_IORD] = 1'b1; end
      S_RTYPE_EX: begin v[B_ALUSRCA] = 1'b1; v[B_ALUOP+:2] = 2'b10; end
      S_RTYPE_WB: begin v[B_REGDST] = 1'b1; v[B_REGWRITE] = 1'b1; end
      S_BEQ_EX: begin
        v[B_ALUSRCA] = 1'b1; v[B_ALUOP+:2] = 2'b01;
        v[B_PCSRC+:2] = 2'b01; v[B_BRANCH] = 1'b1;
      end
      S_ADDI_EX:  begin v[B_ALUSRCA] = 1'b1; v[B_SRCB+:2] = 2'b10; end
      S_ADDI_WB:  v[B_REGWRITE] = 1'b1;
      S_JUMP_EX:  begin v[B_PCSRC+:2] = 2'b10; v[B_PCWRITE] = 1'b1; end
      S_TRAP:     v[B_ILLEGAL] = 1'b1;
      default:    v = '0;
    endcase
    return v;
  endfunction

  // Instruction-level model: the sequence of phases an opcode walks through.
  task automatic build_path(input logic [5:0] op, input bit addi_en);
    path.delete();
    path.push_back(S_FETCH);
    path.push_back(S_DECODE);
    case (op)
      OP_LW:    begin path.push_back(S_MEMADR); path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
      OP_SW:    begin path.push_back(S_MEMADR); path.push_back(S_MEMWR); end
      OP_RTYPE: begin path.push_back(S_RTYPE_EX); path.push_back(S_RTYPE_WB); end
      OP_BEQ:   path.push_back(S_BEQ_EX);
      OP_J:     path.push_back(S_JUMP_EX);
      OP_ADDI: begin
        if (addi_en) begin path.push_back(S_ADDI_EX); path.push_back(S_ADDI_WB); end
        else path.push_back(S_TRAP);
      end
      default:  path.push_back(S_TRAP);
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'($urandom);
    #1;
    check("rst_state", 32'(a_state), 32'(S_FETCH));
    check("rst_ctrl", 32'(obs_vec(1'b0)), 32'(exp_vec(S_FETCH, 1'b0)));
    check("rst_state_alt", 32'(b_state), 32'(S_FETCH));
    check("rst_ctrl_alt", 32'(obs_vec(1'b1)), 32'(exp_vec(S_FETCH, 1'b0)));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH back to FETCH. Entered and left at a
  // negedge; fw/mw are not-ready cycles in FETCH and in MEMRD/MEMWR.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input bit alt, input bit abort_memwr);
    bit hs;
    int n_rw, n_ill, n_mw, exp_rw, exp_ill, exp_mw;
    hs = !alt;
    n_rw = 0; n_ill = 0; n_mw = 0;
    build_path(op, !alt);
    exp_rw = 0; exp_ill = 0; exp_mw = 0;
    foreach (path[i]) begin
      if (path[i] inside {S_MEMWB, S_RTYPE_WB, S_ADDI_WB}) exp_rw = 1;
      if (path[i] == S_TRAP) exp_ill = 1;
    end
    opcode = op;
    foreach (path[i]) begin
      bit is_wait, rdy, done;
      int waits, k;
      is_wait = path[i] inside {S_FETCH, S_MEMRD, S_MEMWR};
      waits = (path[i] == S_FETCH) ? fw : mw;
      k = 0;
      done = 1'b0;
      while (!done) begin
        if (i >= 2) opcode = 6'($urandom);
        if (hs && is_wait) mem_ready = (k < waits) ? 1'b0 : 1'b1;
        else mem_ready = 1'($urandom);
        rdy = hs ? mem_ready : 1'b1;
        if (path[i] == S_MEMWR && rdy) exp_mw += 1;
        else if (path[i] == S_MEMWR) exp_mw += 1;
        #1;
        check("state", 32'(obs_state(alt)), 32'(path[i]));
        check("ctrl", 32'(obs_vec(alt)), 32'(exp_vec(path[i], rdy)));
        n_rw  += int'(obs_vec(alt)[B_REGWRITE]);
        n_ill += int'(obs_vec(alt)[B_ILLEGAL]);
        n_mw  += int'(obs_vec(alt)[B_MEMWRITE]);
        if (abort_memwr && path[i] == S_MEMWR) begin
          #2 reset = 1'b1;
          #1;
          check("abort_memwrite", 32'(obs_vec(alt)[B_MEMWRITE]), 32'd0);
          check("abort_state", 32'(obs_state(alt)), 32'(S_FETCH));
          check("abort_ctrl", 32'(obs_vec(alt)), 32'(exp_vec(S_FETCH, 1'b0)));
          @(negedge clk);
          reset = 1'b0;
          return;
        end
        done = !(is_wait && !rdy);
        k++;
        @(negedge clk);
      end
    end
    check("regwrite_cycles", 32'(n_rw), 32'(exp_rw));
    check("illegal_cycles", 32'(n_ill), 32'(exp_ill));
    check("memwrite_cycles", 32'(n_mw), 32'(exp_mw));
    check("back_to_fetch", 32'(obs_state(alt)), 32'(S_FETCH));
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_RTYPE;
      3: return OP_BEQ;
      4: return OP_J;
      5: return OP_ADDI;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    do_reset();

    // Handshaking instance: directed scenarios.
    run_instr(OP_LW, 2, 2, 1'b0, 1'b0);
    run_instr(OP_SW, 0, 0, 1'b0, 1'b0);
    run_instr(OP_RTYPE, 0, 0, 1'b0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
    run_instr(OP_BEQ, 1, 0, 1'b0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0, 1'b0);
    run_instr(OP_SW, 1, 3, 1'b0, 1'b1);
    run_instr(OP_LW, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++)
      run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);

    // No-handshake, addi-disabled instance.
    do_reset();
    run_instr(OP_RTYPE, 0, 0, 1'b1, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b1, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b1, 1'b0);
    run_instr(OP_LW, 0, 0, 1'b1, 1'b0);
    run_instr(OP_SW, 0, 0, 1'b1, 1'b0);
    for (int n = 0; n < 20; n++)
      run_instr(pick_op(), 0, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_HS, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 Parameter ADDI_EN, default 1, meaning: 1 = addi (001000) decoded; 0 = addi treated as illegal.
REQ-003 Port clk, input, 1, meaning: the single clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1, meaning: asynchronous, active-high reset.
REQ-005 Port opcode, input, 6, meaning: instruction register bits [31:26], sampled in DECODE.
REQ-006 Port mem_ready, input, 1, meaning: memory completion for the current read or write.
REQ-007 Port pcwrite, output, 1, meaning: unconditional PC load.
REQ-008 Port branch, output, 1, meaning: PC load qualified by ALU zero.
REQ-009 Port iord, memread, memwrite, irwrite, output, 1 each, meaning: memory address select (0 = PC, 1 = ALUOut), read strobe, write strobe, IR load.
REQ-010 Port regdst, memtoreg, regwrite, alusrca, output, 1 each, meaning: datapath selects and register-file write enable.
REQ-011 Port alusrcb, aluop, pcsrc, output, 2 each, meaning: ALU B select, ALU op class (00 add, 01 sub, 10 funct), PC source (00 ALU, 01 ALUOut, 10 jump).
REQ-012 Port illegal, output, 1, meaning: one-cycle pulse on an undecoded opcode.
REQ-013 Port state, output, 4, meaning: current FSM state, for debug.

Function
REQ-014 The FSM SHALL be Moore; the only exception is that irwrite and pcwrite in FETCH SHALL be gated by the effective mem_ready.
REQ-015 Outputs not listed for a state SHALL be 0.
REQ-016 FETCH: memread=1, alusrcb=01. On effective mem_ready: irwrite=1, pcwrite=1, go to DECODE; otherwise stay in FETCH.
REQ-017 DECODE: alusrcb=11, then transition by opcode: 100011 or 101011 to MEMADR, 000000 to RTYPE_EX, 000100 to BEQ_EX, 000010 to JUMP_EX, 001000 with ADDI_EN=1 to ADDI_EX, anything else to TRAP.
REQ-018 MEMADR: alusrca=1, alusrcb=10; go to MEMRD for lw and to MEMWR for sw, using the opcode latched in DECODE.
REQ-019 MEMRD: memread=1, iord=1; stay until effective mem_ready, then go to MEMWB.
REQ-020 MEMWB: memtoreg=1, regwrite=1; then go to FETCH.
REQ-021 MEMWR: memwrite=1, iord=1; stay until effective mem_ready, then go to FETCH.
REQ-022 RTYPE_EX: alusrca=1, aluop=10; then go to RTYPE_WB. RTYPE_WB: regdst=1, regwrite=1; then go to FETCH.
REQ-023 BEQ_EX: alusrca=1, aluop=01, pcsrc=01, branch=1; then go to FETCH.
REQ-024 ADDI_EX: alusrca=1, alusrcb=10; then go to ADDI_WB. ADDI_WB: regwrite=1; then go to FETCH.
REQ-025 JUMP_EX: pcsrc=10, pcwrite=1; then go to FETCH.
REQ-026 TRAP: illegal=1 for exactly one cycle, no register or memory write; then go to FETCH.
REQ-027 Latency with zero-wait memory, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3.
REQ-028 The opcode SHALL be latched internally at the DECODE edge; opcode changes after that edge SHALL NOT alter the path.
REQ-029 mem_ready asserted in a non-memory state SHALL be ignored.
REQ-030 memread and memwrite SHALL never be high in the same cycle.

Reset
REQ-031 While reset=1: state=FETCH, latched opcode=000000, all outputs 0 except memread=1 and alusrcb=01 (FETCH values with mem_ready gating forced off).
REQ-032 Reset asserted mid-operation (for example in MEMWR) SHALL drop memwrite asynchronously, within the same cycle.
REQ-033 The first FETCH SHALL begin on the first rising edge after reset deasserts.

Structure
REQ-034 Package mips_pkg SHALL hold the opcode constants, the state encoding (4-bit enum), and the aluop, alusrcb and pcsrc encodings.
REQ-035 The state-to-output decode SHALL be one combinational sub-module, mc_control_outs; next-state logic and registers SHALL stay in mc_control.

Verification
REQ-036 lw (100011), mem_ready low for 2 cycles in both FETCH and MEMRD -> state sequence FETCH×3, DECODE, MEMADR, MEMRD×3, MEMWB; regwrite=1 with memtoreg=1 exactly once.
REQ-037 R-type (000000), MEM_HS=0 -> 4 cycles; aluop=10 in RTYPE_EX; regdst=1 and regwrite=1 in RTYPE_WB.
REQ-038 beq (000100) -> 3 cycles; branch=1, pcsrc=01, aluop=01 in one cycle; regwrite never high.
REQ-039 Opcode 111111, and addi with ADDI_EN=0 -> TRAP; illegal is a one-cycle pulse; memwrite and regwrite stay 0; returns to FETCH.
REQ-040 sw (101011), reset asserted mid-MEMWR -> memwrite falls immediately; state=FETCH; after release, the first fetch completes normally.
REQ-041 j (000010), opcode toggled after DECODE -> JUMP_EX taken regardless; pcsrc=10 and pcwrite=1 for one cycle.
